// File: rtl/rhythm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rhythm_pkg
// Description : Shared state encoding, keycodes and helpers for the rhythm
//               game flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rhythm_pkg;

  typedef enum logic [2:0] {
    ST_MAIN  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_SPAWN = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_SCORE = 3'd5,
    ST_PASS  = 3'd6,
    ST_FAIL  = 3'd7
  } state_e;

  localparam logic [7:0] KC_SPACE = 8'd44;
  localparam logic [7:0] KC_Q     = 8'd20;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rhythm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rhythm_sequencer_if
// Description : Key/hit inputs and screen/spawn outputs of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rhythm_sequencer_if #(
  parameter int NUM_BEATS = 4,
  parameter int TYPE_W    = 2
);
  localparam int IDX_W = $clog2(NUM_BEATS + 1);

  logic [7:0]        keycode;
  logic              hit;
  logic              main;
  logic              playbackground;
  logic              fail;
  logic              success;
  logic              spawn;
  logic [TYPE_W-1:0] circletype;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  hit_count;

  modport master (
    input  keycode, hit,
    output main, playbackground, fail, success, spawn, circletype, beat_idx, hit_count
  );

  modport slave (
    output keycode, hit,
    input  main, playbackground, fail, success, spawn, circletype, beat_idx, hit_count
  );

endinterface
`default_nettype wire

// File: rtl/beat_pattern_rom.sv
`default_nettype none
// ============================================================================
// Module      : beat_pattern_rom
// Description : Combinational beat index to circle type lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_pattern_rom #(
  parameter int NUM_BEATS = 4,
  parameter int TYPE_W    = 2,
  localparam int IDX_W    = $clog2(NUM_BEATS + 1)
) (
  input  logic [IDX_W-1:0]  beat_idx,
  output logic [TYPE_W-1:0] circletype
);

  // Depth rounded to the full index range so every index value is addressable.
  localparam int ROM_DEPTH = 1 << IDX_W;

  logic [TYPE_W-1:0] rom [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    if (i < NUM_BEATS) begin : g_used
      assign rom[i] = TYPE_W'(i % (1 << TYPE_W));
    end else begin : g_pad
      assign rom[i] = '0;
    end
  end

  always_comb begin
    circletype = rom[beat_idx];
  end

endmodule
`default_nettype wire

// File: rtl/rhythm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rhythm_sequencer
// Description : Game flow controller: main screen, timed beat spawning,
//               hit scoring and pass/fail screens.
// Revision    : 1.0 - initial release
// ============================================================================
module rhythm_sequencer
  import rhythm_pkg::*;
#(
  parameter int         NUM_BEATS      = 4,
  parameter int         TYPE_W         = 2,
  parameter int         BEAT_PERIOD    = 8,
  parameter int         TAIL_CYCLES    = 16,
  parameter int         PASS_THRESHOLD = 3,
  parameter logic [7:0] KEY_START      = KC_SPACE,
  parameter logic [7:0] KEY_QUIT       = KC_Q
) (
  input  logic              Clk,
  input  logic              Reset,
  rhythm_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(NUM_BEATS + 1);
  localparam int CNT_W = $clog2(max2(BEAT_PERIOD, TAIL_CYCLES) + 1);

  state_e           state_q, state_d;
  logic [7:0]       key_prev_q, key_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] hits_q, hits_d;

  logic              start_evt;
  logic              quit_evt;
  logic              in_song;
  logic              counting;
  logic [TYPE_W-1:0] rom_type;

  beat_pattern_rom #(
    .NUM_BEATS (NUM_BEATS),
    .TYPE_W    (TYPE_W)
  ) u_rom (
    .beat_idx   (beat_q),
    .circletype (rom_type)
  );

  assign start_evt = (bus.keycode == KEY_START) && (key_prev_q != KEY_START);
  assign quit_evt  = (bus.keycode == KEY_QUIT)  && (key_prev_q != KEY_QUIT);
  assign in_song   = (state_q == ST_PLAY) || (state_q == ST_SPAWN) || (state_q == ST_WAIT) ||
                     (state_q == ST_TAIL) || (state_q == ST_SCORE);
  assign counting  = (state_q == ST_SPAWN) || (state_q == ST_WAIT) || (state_q == ST_TAIL);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_MAIN;
      key_prev_q <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      hits_q     <= '0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_prev_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      hits_q     <= hits_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_prev_d = bus.keycode;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    hits_d     = hits_q;

    // A hit coinciding with quit is dropped so the frozen score excludes it.
    if (bus.hit && counting && !quit_evt && (hits_q != IDX_W'(NUM_BEATS))) begin
      hits_d = hits_q + 1'b1;
    end

    case (state_q)
      ST_MAIN: if (start_evt) state_d = ST_PLAY;
      ST_PLAY: begin
        hits_d  = '0;
        beat_d  = '0;
        cnt_d   = '0;
        state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        cnt_d   = CNT_W'(BEAT_PERIOD - 2);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (beat_q == IDX_W'(NUM_BEATS - 1)) begin
          cnt_d   = CNT_W'(TAIL_CYCLES - 1);
          state_d = ST_TAIL;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = ST_SPAWN;
        end
      end
      ST_TAIL: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_SCORE;
      end
      ST_SCORE: state_d = (hits_q >= IDX_W'(PASS_THRESHOLD)) ? ST_PASS : ST_FAIL;
      ST_PASS:  if (start_evt) state_d = ST_MAIN;
      ST_FAIL:  if (start_evt) state_d = ST_MAIN;
      default:  state_d = ST_MAIN;
    endcase

    if (quit_evt && in_song) state_d = ST_FAIL;
  end

  always_comb begin
    bus.main           = (state_q == ST_MAIN);
    bus.playbackground = in_song;
    bus.fail           = (state_q == ST_FAIL);
    bus.success        = (state_q == ST_PASS);
    bus.spawn          = (state_q == ST_SPAWN);
    bus.circletype     = (state_q == ST_SPAWN) ? rom_type : '0;
    bus.beat_idx       = beat_q;
    bus.hit_count      = hits_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rhythm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rhythm_sequencer
// Description : Self-checking bench with a spawn scoreboard for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rhythm_sequencer;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  rhythm_sequencer_if #(.NUM_BEATS(4), .TYPE_W(2)) bus ();

  rhythm_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         exp_cyc[$];
  logic [1:0] exp_type[$];

  always @(posedge Clk) cyc++;

  // Scoreboard: every spawn pulse is matched against the next expected one.
  always @(negedge Clk) begin
    if (bus.spawn === 1'b1) begin
      int         ec;
      logic [1:0] et;
      checks++;
      if (exp_cyc.size() == 0) begin
        errors++;
        $display("FAIL spawn_unexpected: spawn at cycle %0d, none expected", cyc);
      end else begin
        ec = exp_cyc.pop_front();
        et = exp_type.pop_front();
        if (cyc !== ec || bus.circletype !== et) begin
          errors++;
          $display("FAIL spawn_match: got cycle %0d type %0d, expected cycle %0d type %0d",
                   cyc, bus.circletype, ec, et);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_hit(input int c);
    wait_to(c);
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
  endtask

  task automatic start_song(output int t0, input int n_spawns);
    bus.keycode = 8'd44;
    t0 = cyc;
    for (int i = 0; i < n_spawns; i++) begin
      exp_cyc.push_back(t0 + 2 + 8 * i);
      exp_type.push_back(2'(i % 4));
    end
    step();
    bus.keycode = 8'd0;
  endtask

  task automatic press_start();
    bus.keycode = 8'd44;
    step();
    bus.keycode = 8'd0;
    step();
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_cyc.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected spawns missing, expected 0", name, exp_cyc.size());
      exp_cyc.delete();
      exp_type.delete();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    checks++;
    if ({bus.main, bus.playbackground, bus.fail, bus.success, bus.spawn} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 10000",
               {bus.main, bus.playbackground, bus.fail, bus.success, bus.spawn});
    end
    checks++;
    if (bus.circletype !== 2'd0 || bus.beat_idx !== 3'd0 || bus.hit_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: got type %0d beat %0d hits %0d, expected 0 0 0",
               bus.circletype, bus.beat_idx, bus.hit_count);
    end
  endtask

  task automatic test_no_hits();
    int t0;
    start_song(t0, 4);
    wait_to(t0 + 50);
    checks++;
    if (bus.playbackground !== 1'b1 || bus.fail !== 1'b0) begin
      errors++;
      $display("FAIL no_hits_score: got pb %b fail %b, expected 1 0", bus.playbackground, bus.fail);
    end
    step();
    checks++;
    if (bus.fail !== 1'b1 || bus.success !== 1'b0 || bus.hit_count !== 3'd0) begin
      errors++;
      $display("FAIL no_hits_result: got fail %b success %b hits %0d, expected 1 0 0",
               bus.fail, bus.success, bus.hit_count);
    end
    check_sb_empty("no_hits_spawns");
    press_start();
  endtask

  task automatic test_pass();
    int t0;
    start_song(t0, 4);
    pulse_hit(t0 + 5);
    pulse_hit(t0 + 13);
    pulse_hit(t0 + 40);
    wait_to(t0 + 51);
    checks++;
    if (bus.success !== 1'b1 || bus.hit_count !== 3'd3) begin
      errors++;
      $display("FAIL pass_result: got success %b hits %0d, expected 1 3", bus.success, bus.hit_count);
    end
    check_sb_empty("pass_spawns");
    pulse_hit(cyc);
    step();
    checks++;
    if (bus.success !== 1'b1 || bus.hit_count !== 3'd3) begin
      errors++;
      $display("FAIL pass_hit_ignored: got success %b hits %0d, expected 1 3", bus.success, bus.hit_count);
    end
  endtask

  task automatic test_held_key();
    bus.keycode = 8'd44;
    step();
    checks++;
    if (bus.main !== 1'b1 || bus.success !== 1'b0) begin
      errors++;
      $display("FAIL held_to_main: got main %b success %b, expected 1 0", bus.main, bus.success);
    end
    for (int i = 0; i < 19; i++) begin
      step();
      checks++;
      if (bus.main !== 1'b1 || bus.playbackground !== 1'b0) begin
        errors++;
        $display("FAIL held_no_restart: cycle %0d got main %b pb %b, expected 1 0",
                 i, bus.main, bus.playbackground);
      end
    end
    bus.keycode = 8'd0;
    pulse_hit(cyc);
    checks++;
    if (bus.hit_count !== 3'd3) begin
      errors++;
      $display("FAIL main_hit_ignored: got hits %0d, expected 3", bus.hit_count);
    end
    bus.keycode = 8'd44;
    step();
    checks++;
    if (bus.playbackground !== 1'b1 || bus.main !== 1'b0 || bus.spawn !== 1'b0) begin
      errors++;
      $display("FAIL repress_play: got pb %b main %b spawn %b, expected 1 0 0",
               bus.playbackground, bus.main, bus.spawn);
    end
    bus.keycode = 8'd0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_quit();
    int t0;
    start_song(t0, 2);
    pulse_hit(t0 + 5);
    wait_to(t0 + 12);
    bus.keycode = 8'd20;
    step();
    bus.keycode = 8'd0;
    checks++;
    if (bus.fail !== 1'b1 || bus.playbackground !== 1'b0 || bus.hit_count !== 3'd1) begin
      errors++;
      $display("FAIL quit_fail: got fail %b pb %b hits %0d, expected 1 0 1",
               bus.fail, bus.playbackground, bus.hit_count);
    end
    pulse_hit(t0 + 20);
    wait_to(t0 + 40);
    checks++;
    if (bus.fail !== 1'b1 || bus.hit_count !== 3'd1) begin
      errors++;
      $display("FAIL quit_frozen: got fail %b hits %0d, expected 1 1", bus.fail, bus.hit_count);
    end
    check_sb_empty("quit_spawns");
    press_start();
  endtask

  task automatic test_saturation();
    int t0;
    start_song(t0, 4);
    wait_to(t0 + 3);
    bus.hit = 1'b1;
    wait_to(t0 + 9);
    bus.hit = 1'b0;
    checks++;
    if (bus.hit_count !== 3'd4) begin
      errors++;
      $display("FAIL saturate: got hits %0d, expected 4", bus.hit_count);
    end
    wait_to(t0 + 51);
    checks++;
    if (bus.success !== 1'b1 || bus.hit_count !== 3'd4) begin
      errors++;
      $display("FAIL saturate_pass: got success %b hits %0d, expected 1 4", bus.success, bus.hit_count);
    end
    check_sb_empty("saturate_spawns");
    press_start();
  endtask

  task automatic test_reset_mid();
    int t0;
    start_song(t0, 3);
    pulse_hit(t0 + 6);
    wait_to(t0 + 18);
    checks++;
    if (bus.spawn !== 1'b1 || bus.beat_idx !== 3'd2) begin
      errors++;
      $display("FAIL mid_beat_idx: got spawn %b beat %0d, expected 1 2", bus.spawn, bus.beat_idx);
    end
    wait_to(t0 + 20);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++;
    if (bus.main !== 1'b1 || bus.beat_idx !== 3'd0 || bus.hit_count !== 3'd0 || bus.spawn !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got main %b beat %0d hits %0d spawn %b, expected 1 0 0 0",
               bus.main, bus.beat_idx, bus.hit_count, bus.spawn);
    end
    check_sb_empty("mid_reset_spawns");
    step();
    start_song(t0, 4);
    wait_to(t0 + 51);
    checks++;
    if (bus.fail !== 1'b1 || bus.hit_count !== 3'd0) begin
      errors++;
      $display("FAIL replay_result: got fail %b hits %0d, expected 1 0", bus.fail, bus.hit_count);
    end
    check_sb_empty("replay_spawns");
  endtask

  initial begin
    bus.keycode = 8'd0;
    bus.hit     = 1'b0;
    test_reset();
    test_no_hits();
    test_pass();
    test_held_key();
    test_quit();
    test_saturation();
    test_reset_mid();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
